// File: rtl/nps_axi_mem.sv
// AXI4 slave over a word-wide on-chip SRAM. INCR bursts of 4-byte beats,
// one transaction at a time, with write and read sharing a single FSM.
module nps_axi_mem #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_arstn,
    input  logic [5:0]  s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [5:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [5:0]  s_axi_arid,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [5:0]  s_axi_rid,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WDAT, WRSP, RDAT} state_t;

    state_t      state_q, state_d;
    logic        rdy_q;
    logic        last_wr_q;
    logic [5:0]  id_q;
    logic [29:0] base_q;
    logic [7:0]  len_q;
    logic        err_q;
    logic        werr_q;
    logic [8:0]  beat_q;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_mem_p1;
    logic        vld_p1_q, last_p1_q, err_p1_q;
    logic [31:0] fdata_q [2];
    logic [1:0]  fresp_q [2];
    logic        flast_q [2];
    logic [1:0]  cnt_q;

    logic        aw_hs, ar_hs, w_hs, w_en, r_pop, issue, oor, at_len, push_slot;
    logic [30:0] beat_idx;
    logic [2:0]  occ;
    logic [31:0] push_data;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Contested requests go to whichever side did not win last time.
    assign s_axi_awready = rdy_q && (state_q == IDLE) && (!s_axi_arvalid || !last_wr_q);
    assign s_axi_arready = rdy_q && (state_q == IDLE) && (!s_axi_awvalid || last_wr_q);
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    assign s_axi_wready = (state_q == WDAT);
    assign w_hs         = s_axi_wvalid && s_axi_wready;
    assign s_axi_bvalid = (state_q == WRSP);
    assign s_axi_bid    = id_q;
    assign s_axi_bresp  = (s_axi_bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

    assign s_axi_rvalid = (cnt_q != 2'd0);
    assign s_axi_rid    = id_q;
    assign s_axi_rdata  = fdata_q[0];
    assign s_axi_rresp  = fresp_q[0];
    assign s_axi_rlast  = flast_q[0];
    assign r_pop        = s_axi_rvalid && s_axi_rready;

    // Un-truncated word index: beats past the top are dropped, never wrapped.
    assign beat_idx = {1'b0, base_q} + 31'(beat_q);
    assign oor      = (beat_idx >= 31'(DEPTH));
    assign at_len   = (beat_q == {1'b0, len_q});
    assign w_en     = w_hs && !err_q && !oor;

    // Issue a read only if it is guaranteed a skid slot when it lands.
    assign occ       = {1'b0, cnt_q} + {2'b00, vld_p1_q} - {2'b00, r_pop};
    assign issue     = (state_q == RDAT) && (beat_q <= {1'b0, len_q}) && (occ < 3'd2);
    assign push_slot = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !r_pop);
    assign push_data = err_p1_q ? 32'd0 : rd_mem_p1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = WDAT;
                else if (ar_hs) state_d = RDAT;
            end
            WDAT: if (w_hs && (s_axi_wlast || at_len)) state_d = WRSP;
            WRSP: if (s_axi_bready) state_d = IDLE;
            RDAT: if (r_pop && s_axi_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_arstn) begin
        if (!s_axi_arstn) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            last_wr_q <= 1'b0;
            id_q      <= '0;
            base_q    <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            werr_q    <= 1'b0;
            beat_q    <= '0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            err_p1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= 1'b1;
            vld_p1_q <= issue;
            if (aw_hs) begin
                last_wr_q <= 1'b1;
                id_q      <= s_axi_awid;
                base_q    <= s_axi_awaddr[31:2];
                len_q     <= s_axi_awlen;
                err_q     <= (s_axi_awsize != 3'b010) || (s_axi_awburst != 2'b01);
                werr_q    <= (s_axi_awsize != 3'b010) || (s_axi_awburst != 2'b01);
                beat_q    <= '0;
            end else if (ar_hs) begin
                last_wr_q <= 1'b0;
                id_q      <= s_axi_arid;
                base_q    <= s_axi_araddr[31:2];
                len_q     <= s_axi_arlen;
                err_q     <= (s_axi_arsize != 3'b010) || (s_axi_arburst != 2'b01);
                beat_q    <= '0;
            end else if (w_hs) begin
                beat_q <= beat_q + 9'd1;
                if (!w_en || (s_axi_wlast != at_len)) werr_q <= 1'b1;
            end else if (issue) begin
                beat_q <= beat_q + 9'd1;
            end
            if (issue) begin
                last_p1_q <= at_len;
                err_p1_q  <= err_q || oor;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (w_en) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) mem[beat_idx[AW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
        if (issue) rd_mem_p1 <= mem[beat_idx[AW-1:0]];
    end

    // Two-entry skid buffer; entry 0 drives the R channel.
    always_ff @(posedge s_axi_aclk or negedge s_axi_arstn) begin
        if (!s_axi_arstn) begin
            cnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                fresp_q[i] <= '0;
                flast_q[i] <= 1'b0;
            end
        end else begin
            cnt_q <= 2'({1'b0, cnt_q} - {2'b00, r_pop} + {2'b00, vld_p1_q});
            if (r_pop) begin
                fdata_q[0] <= fdata_q[1];
                fresp_q[0] <= fresp_q[1];
                flast_q[0] <= flast_q[1];
            end
            if (vld_p1_q) begin
                fdata_q[push_slot] <= push_data;
                fresp_q[push_slot] <= err_p1_q ? RESP_SLVERR : RESP_OKAY;
                flast_q[push_slot] <= last_p1_q;
            end
        end
    end

endmodule

// File: tb/tb_nps_axi_mem.sv
// Directed bench for nps_axi_mem: vector table of bursts plus hand-written
// sequences for arbitration, back-pressure, range errors and mid-burst reset.
`timescale 1ns/1ps
module tb_nps_axi_mem;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [5:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    nps_axi_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .s_axi_aclk(clk), .s_axi_arstn(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_data [260];
    logic [1:0]  rd_resp [260];
    logic        rd_last [260];
    logic [5:0]  rd_id   [260];

    typedef struct {
        bit          wr;
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [31:0] d0;
        logic [1:0]  resp;
        logic [31:0] exp0;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input logic [31:0] d0, input int nbeats, input int last_idx,
                            output logic [1:0] resp, output logic [5:0] oid,
                            output logic other_rdy, output int stalls);
        int t;
        logic got;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        got = 1'b0; t = 0; other_rdy = 1'b0; stalls = 0; resp = 2'b11; oid = '1;
        while (!got && t < 50) begin
            @(negedge clk); got = awready; other_rdy = arready;
            @(posedge clk); #1; t++;
        end
        awvalid = 1'b0; arvalid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL aw_handshake: awready not seen within 50 cycles");
        end
        for (int k = 0; k < nbeats; k++) begin
            wdata = d0 + 32'(k); wstrb = strb; wlast = (k == last_idx); wvalid = 1'b1;
            got = 1'b0; t = 0;
            while (!got && t < 50) begin
                @(negedge clk); got = wready;
                @(posedge clk); #1; t++;
                if (!got) stalls++;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1; got = 1'b0; t = 0;
        while (!got && t < 50) begin
            @(negedge clk); got = bvalid; resp = bresp; oid = bid;
            @(posedge clk); #1; t++;
        end
        bready = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL b_handshake: bvalid not seen within 50 cycles");
        end
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                           output logic other_rdy, output int nb, output int lat, output int unstable);
        int t, cyc;
        logic got, done, held, hl;
        logic [31:0] hd;
        logic [1:0] hr;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        got = 1'b0; t = 0; other_rdy = 1'b0;
        while (!got && t < 50) begin
            @(negedge clk); got = arready; other_rdy = awready;
            @(posedge clk); #1; t++;
        end
        arvalid = 1'b0; awvalid = 1'b0;
        nb = 0; lat = -1; unstable = 0; cyc = 0; done = 1'b0; held = 1'b0;
        hd = '0; hr = '0; hl = 1'b0;
        rready = 1'b1;
        while (got && !done && cyc < 2000) begin
            @(negedge clk);
            if (held && (!rvalid || rdata !== hd || rresp !== hr || rlast !== hl)) unstable++;
            held = 1'b0;
            if (rvalid && lat < 0) lat = cyc;
            if (rvalid && rready) begin
                if (nb < 260) begin
                    rd_data[nb] = rdata; rd_resp[nb] = rresp; rd_last[nb] = rlast; rd_id[nb] = rid;
                end
                nb++;
                if (rlast) done = 1'b1;
            end else if (rvalid) begin
                held = 1'b1; hd = rdata; hr = rresp; hl = rlast;
            end
            @(posedge clk); #1; cyc++;
            rready = toggle ? ~rready : 1'b1;
        end
        rready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL r_burst: no completed read burst (arready seen=%0d, beats=%0d)", got, nb);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        logic [5:0] i6;
        logic       orr;
        int         st, nb, lat, uns, bad, t;

        tv[0]  = '{1'b1, 6'h05, 32'h100, 8'd3, 3'b010, 2'b01, 4'hF, 32'hA0,        2'b00, 32'h0};
        tv[1]  = '{1'b0, 6'h09, 32'h100, 8'd3, 3'b010, 2'b01, 4'h0, 32'h0,         2'b00, 32'hA0};
        tv[2]  = '{1'b1, 6'h01, 32'h200, 8'd0, 3'b010, 2'b01, 4'hF, 32'hFFFFFFFF,  2'b00, 32'h0};
        tv[3]  = '{1'b1, 6'h02, 32'h200, 8'd0, 3'b010, 2'b01, 4'h5, 32'h11223344,  2'b00, 32'h0};
        tv[4]  = '{1'b0, 6'h03, 32'h200, 8'd0, 3'b010, 2'b01, 4'h0, 32'h0,         2'b00, 32'hFF22FF44};
        tv[5]  = '{1'b1, 6'h2A, 32'h100, 8'd1, 3'b010, 2'b00, 4'hF, 32'hDEAD0000,  2'b10, 32'h0};
        tv[6]  = '{1'b0, 6'h2B, 32'h100, 8'd1, 3'b010, 2'b01, 4'h0, 32'h0,         2'b00, 32'hA0};
        tv[7]  = '{1'b1, 6'h10, 32'h300, 8'd0, 3'b001, 2'b01, 4'hF, 32'h12345678,  2'b10, 32'h0};
        tv[8]  = '{1'b0, 6'h11, 32'h300, 8'd0, 3'b001, 2'b01, 4'h0, 32'h0,         2'b10, 32'h0};
        tv[9]  = '{1'b1, 6'h3F, 32'h102, 8'd0, 3'b010, 2'b01, 4'hF, 32'h55,        2'b00, 32'h0};
        tv[10] = '{1'b0, 6'h3E, 32'h103, 8'd0, 3'b010, 2'b01, 4'h0, 32'h0,         2'b00, 32'h55};

        // Outputs while reset is held
        #12;
        chk("rst awready", 32'(awready), 32'h0);
        chk("rst arready", 32'(arready), 32'h0);
        chk("rst wready",  32'(wready),  32'h0);
        chk("rst bvalid",  32'(bvalid),  32'h0);
        chk("rst rvalid",  32'(rvalid),  32'h0);
        chk("rst rdata",   rdata,        32'h0);
        chk("rst rlast",   32'(rlast),   32'h0);
        chk("rst ids",     32'({bid, rid}), 32'h0);
        chk("rst resps",   32'({bresp, rresp}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            if (tv[i].wr) begin
                do_write(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, tv[i].strb,
                         tv[i].d0, int'(tv[i].len) + 1, int'(tv[i].len), r, i6, orr, st);
                chk($sformatf("v%0d bresp", i), 32'(r), 32'(tv[i].resp));
                chk($sformatf("v%0d bid", i), 32'(i6), 32'(tv[i].id));
                chk($sformatf("v%0d wstalls", i), 32'(st), 32'h0);
            end else begin
                do_read(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, 1'b0,
                        orr, nb, lat, uns);
                chk($sformatf("v%0d beats", i), 32'(nb), 32'(int'(tv[i].len) + 1));
                chk($sformatf("v%0d latency", i), 32'(lat), 32'd2);
                for (int k = 0; k < nb && k <= int'(tv[i].len); k++) begin
                    chk($sformatf("v%0d rdata[%0d]", i, k), rd_data[k], tv[i].exp0 + 32'(k));
                    chk($sformatf("v%0d rresp[%0d]", i, k), 32'(rd_resp[k]), 32'(tv[i].resp));
                    chk($sformatf("v%0d rlast[%0d]", i, k), 32'(rd_last[k]), 32'(k == int'(tv[i].len)));
                    chk($sformatf("v%0d rid[%0d]", i, k), 32'(rd_id[k]), 32'(tv[i].id));
                end
            end
        end

        // Range boundary: no wrap, top beats SLVERR with zero data
        do_write(6'h01, 32'h0, 8'd0, 3'b010, 2'b01, 4'hF, 32'h1234, 1, 0, r, i6, orr, st);
        chk("word0 bresp", 32'(r), 32'h0);
        do_write(6'h04, 32'((DEPTH - 2) * 4), 8'd1, 3'b010, 2'b01, 4'hF, 32'h77, 2, 1, r, i6, orr, st);
        chk("top2 bresp", 32'(r), 32'h0);
        do_read(6'h06, 32'((DEPTH - 2) * 4), 8'd3, 3'b010, 2'b01, 1'b0, orr, nb, lat, uns);
        chk("oor beats", 32'(nb), 32'd4);
        chk("oor d0", rd_data[0], 32'h77);
        chk("oor d1", rd_data[1], 32'h78);
        chk("oor d2", rd_data[2], 32'h0);
        chk("oor d3", rd_data[3], 32'h0);
        chk("oor resps", 32'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 32'b00_00_10_10);
        chk("oor lasts", 32'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 32'b0001);
        do_write(6'h07, 32'((DEPTH - 1) * 4), 8'd1, 3'b010, 2'b01, 4'hF, 32'h99, 2, 1, r, i6, orr, st);
        chk("oor wr bresp", 32'(r), 32'h2);
        do_read(6'h08, 32'((DEPTH - 1) * 4), 8'd0, 3'b010, 2'b01, 1'b0, orr, nb, lat, uns);
        chk("oor wr kept beat0", rd_data[0], 32'h99);
        do_read(6'h08, 32'h0, 8'd0, 3'b010, 2'b01, 1'b0, orr, nb, lat, uns);
        chk("no wrap word0", rd_data[0], 32'h1234);

        // wlast early and late
        do_write(6'h0A, 32'h500, 8'd3, 3'b010, 2'b01, 4'hF, 32'h0, 2, 1, r, i6, orr, st);
        chk("early wlast bresp", 32'(r), 32'h2);
        do_write(6'h0B, 32'h600, 8'd1, 3'b010, 2'b01, 4'hF, 32'h0, 2, 9, r, i6, orr, st);
        chk("late wlast bresp", 32'(r), 32'h2);
        chk("late wlast stalls", 32'(st), 32'h0);

        // 256-beat read with rready toggling
        do_write(6'h0C, 32'h2000, 8'd255, 3'b010, 2'b01, 4'hF, 32'h5A000000, 256, 255, r, i6, orr, st);
        chk("b256 bresp", 32'(r), 32'h0);
        do_read(6'h0D, 32'h2000, 8'd255, 3'b010, 2'b01, 1'b1, orr, nb, lat, uns);
        chk("b256 beats", 32'(nb), 32'd256);
        chk("b256 unstable", 32'(uns), 32'd0);
        bad = 0;
        for (int k = 0; k < 256 && k < nb; k++) begin
            if (rd_data[k] !== 32'h5A000000 + 32'(k) || rd_resp[k] !== 2'b00 ||
                rd_last[k] !== (k == 255) || rd_id[k] !== 6'h0D) bad++;
        end
        chk("b256 beat errors", 32'(bad), 32'd0);

        // Reset in the middle of a read burst
        araddr = 32'h2000; arlen = 8'd7; arsize = 3'b010; arburst = 2'b01; arid = 6'h15; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid rvalid before rst", 32'(rvalid), 32'h1);
        #3; rst_n = 1'b0; #1;
        chk("mid rst rvalid", 32'(rvalid), 32'h0);
        chk("mid rst rdata", rdata, 32'h0);
        chk("mid rst readies", 32'({arready, awready, wready}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid || bvalid) bad++;
        end
        rready = 1'b0;
        chk("post rst no completion", 32'(bad), 32'd0);
        @(posedge clk); #1;

        // Simultaneous AW and AR after reset: write first, then read
        araddr = 32'h100; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01; arid = 6'h22; arvalid = 1'b1;
        do_write(6'h21, 32'h700, 8'd0, 3'b010, 2'b01, 4'hF, 32'hC0DE, 1, 0, r, i6, orr, st);
        chk("rr1 arready at aw grant", 32'(orr), 32'h0);
        chk("rr1 bresp", 32'(r), 32'h0);
        chk("rr1 bid", 32'(i6), 32'h21);
        awaddr = 32'h700; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01; awid = 6'h23; awvalid = 1'b1;
        do_read(6'h22, 32'h100, 8'd0, 3'b010, 2'b01, 1'b0, orr, nb, lat, uns);
        chk("rr2 awready at ar grant", 32'(orr), 32'h0);
        chk("rr2 rdata", rd_data[0], 32'h55);
        chk("rr2 rid", 32'(rd_id[0]), 32'h22);
        do_read(6'h24, 32'h700, 8'd0, 3'b010, 2'b01, 1'b0, orr, nb, lat, uns);
        chk("rr write data", rd_data[0], 32'hC0DE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nps_axi_mem.md
Name: nps_axi_mem

Overview:
- AXI4 slave (responder) with on-chip word SRAM; the far end of the npm AXI master.
- Terminates npm INCR bursts: awsize=4 B, 1..256 beats, one transaction at a time.
- Used as NPU local/scratch memory and as the bench target for npm.
- Write and read channels share one arbitrated state machine; one transaction outstanding.

Parameters:
DEPTH, 4096, number of 32-bit words; power of 2, ≥ 256
AW, 12, word-index width = log2(DEPTH)

Ports:
s_axi_aclk  in  1  clock, all logic on rising edge
s_axi_arstn  in  1  asynchronous active-low reset
s_axi_awid  in  6  write ID
s_axi_awaddr  in  32  write byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  must be 3'b010
s_axi_awburst  in  2  must be 2'b01 (INCR)
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  6  echoed awid
s_axi_bresp  out  2  OKAY 2'b00 / SLVERR 2'b10
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  6  read ID
s_axi_araddr  in  32  read byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  must be 3'b010
s_axi_arburst  in  2  must be 2'b01
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  6  echoed arid
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  per-beat response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset: state IDLE; all outputs 0 (readies, valids, ids, resp, rdata, rlast). SRAM contents not reset.
- Reset mid-burst: transaction abandoned, outputs return to 0 asynchronously; no B/R completes.
- FSM states IDLE, WDAT, WRSP, RDAT.
- IDLE: awready = arready = 1 only when no request is pending.
  - AW only → latch id/addr/len/err, go to WDAT. AR only → latch, go to RDAT.
  - AW and AR in the same cycle: round-robin on a last-grant bit; first after reset goes to write. Loser's ready is 0 that cycle, so it is not accepted.
- Word index: addr[AW+1:2], incremented by 1 per beat. addr[1:0] ignored.
- A beat is out of range when the un-truncated word index (addr>>2 plus beat count) ≥ DEPTH. There is no wrap to 0.
- Error flag: set if size ≠ 3'b010 or burst ≠ 2'b01. When set, the whole transaction is SLVERR.
- WDAT:
  - wready = 1; each W handshake writes the bytes enabled by wstrb, unless the beat is out of range or the error flag is set.
  - Beat counter reaches len on the wlast handshake → go to WRSP.
  - wlast earlier or later than len → bresp SLVERR. Exit happens on the wlast handshake or when the beat count exceeds len, whichever is first.
- WRSP: bvalid = 1 with bid; bresp = SLVERR if any error or dropped beat, else OKAY. bready handshake → IDLE.
- RDAT:
  - Synchronous SRAM read; first rvalid exactly 2 cycles after the AR handshake.
  - Sustains 1 beat/cycle while rready = 1.
  - When rready = 0: rdata/rresp/rlast/rvalid held stable, using a 2-entry skid buffer.
  - Out-of-range or error beat: rdata = 0, rresp = SLVERR; otherwise OKAY.
  - rlast on beat len; its handshake → IDLE.
- Back-to-back: next AW/AR may be accepted the cycle after B or the last R handshake.

Test Plan:
1. Write awaddr 0x100, awlen 3, data 0xA0..0xA3, wstrb F, bready 1 → wready each beat; bvalid ≥1 cycle after wlast, bresp 00, bid = awid.
2. Read araddr 0x100, arlen 3 → rdata 0xA0..0xA3 with rlast on beat 4 only, rid = arid, rresp 00; first rvalid 2 cycles after AR handshake.
3. Read 256 beats with rready toggled 1010…. → no lost or duplicated data, outputs stable while rready 0; rlast on beat 256.
4. Write 0x11223344 with wstrb 0101 over 0xFFFFFFFF → readback 0xFF22FF44.
5. Simultaneous AW and AR from reset → write granted first; the next simultaneous pair grants read.
6. Out-of-range and error cases:
   - araddr = (DEPTH-2)*4, arlen 3 → beats 1-2 OKAY; beats 3-4 rdata 0, rresp 10.
   - awburst 2'b00 → bresp 10, memory unchanged.
